// File: rtl/mdu_issue_ctrl.sv
// M-extension issue controller: accepts one M-op, launches it on the multiplier or divider and returns the result with its rd tag.
// Optional feature macro: MDU_DIV_SPECIAL_EN resolves divide-by-zero and signed overflow locally without launching the divider.
module mdu_issue_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_in_valid,
  output logic [1:0]       mul_type,
  output logic [31:0]      multiplier,
  output logic [31:0]      multiplicand,
  input  logic [31:0]      mul_out,
  input  logic             mul_out_valid,
  input  logic             mul_busy,
  output logic             mul_cpu_busy,
  output logic             div_in_valid,
  output logic [1:0]       div_type,
  output logic [31:0]      dividend,
  output logic [31:0]      divisor,
  input  logic [31:0]      div_out,
  input  logic             div_out_valid,
  input  logic             div_busy,
  output logic             div_cpu_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_MUL,
    S_WAIT_DIV,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [F3_W-1:0]   r_funct3;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_resp_data;
  logic [XLEN-1:0]   w_resp_nxt;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_load_resp;
  logic              w_mul_launch;
  logic              w_div_launch;
  logic              w_unit_done;

`ifdef MDU_DIV_SPECIAL_EN
  // Divide corner cases answered directly from the request operands.
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  assign w_div_zero    = (req_rs2 == '0);
  assign w_div_ovf     = !req_funct3[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign w_special     = req_funct3[2] && (w_div_zero || w_div_ovf);
  assign w_special_res = w_div_zero ? (req_funct3[1] ? req_rs1 : '1)
                                    : (req_funct3[1] ? '0 : 32'h8000_0000);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_load_resp  = 1'b0;
    w_resp_nxt   = r_resp_data;
    w_mul_launch = 1'b0;
    w_div_launch = 1'b0;
    w_req_ready  = (r_state == S_IDLE) && !flush;
    w_unit_done  = r_funct3[2] ? div_out_valid : mul_out_valid;
    case (r_state)
      S_IDLE: begin
        if (req_valid && w_req_ready) begin
          w_accept = 1'b1;
`ifdef MDU_DIV_SPECIAL_EN
          if (w_special) begin
            w_load_resp = 1'b1;
            w_resp_nxt  = w_special_res;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_ISSUE;
          end
`else
          w_state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_funct3[2]) begin
          if (!div_busy) begin
            w_div_launch = 1'b1;
            w_state_nxt  = S_WAIT_DIV;
          end
        end else if (!mul_busy) begin
          w_mul_launch = 1'b1;
          w_state_nxt  = S_WAIT_MUL;
        end
      end
      S_WAIT_MUL: begin
        // A result arriving in the flush cycle is simply discarded; nothing is left to drain.
        if (flush) begin
          w_state_nxt = mul_out_valid ? S_IDLE : S_DRAIN;
        end else if (mul_out_valid) begin
          w_load_resp = 1'b1;
          w_resp_nxt  = mul_out;
          w_state_nxt = S_RESP;
        end
      end
      S_WAIT_DIV: begin
        if (flush) begin
          w_state_nxt = div_out_valid ? S_IDLE : S_DRAIN;
        end else if (div_out_valid) begin
          w_load_resp = 1'b1;
          w_resp_nxt  = div_out;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_unit_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand and response holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_tag       <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_rs1    <= req_rs1;
        r_rs2    <= req_rs2;
        r_tag    <= req_tag;
      end
      if (w_load_resp) begin
        r_resp_data <= w_resp_nxt;
      end
    end
  end

  assign req_ready    = w_req_ready;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data    = r_resp_data;
  assign resp_tag     = r_tag;
  assign mul_in_valid = w_mul_launch;
  assign mul_type     = r_funct3[1:0];
  assign multiplier   = r_rs2;
  assign multiplicand = r_rs1;
  assign mul_cpu_busy = (r_state != S_WAIT_MUL) && (r_state != S_DRAIN);
  assign div_in_valid = w_div_launch;
  assign div_type     = r_funct3[1:0];
  assign dividend     = r_rs1;
  assign divisor      = r_rs2;
  assign div_cpu_busy = (r_state != S_WAIT_DIV) && (r_state != S_DRAIN);

endmodule
